// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared definitions for the 4:1 time-division link. Both the receive
// demultiplexer and the transmit-side select sequencer use these.
//   LANES     : lanes per frame (word width), must be >= 2
//   SELW      : slot/select width, clog2(LANES)
//   LAST_LANE : lane that carries the start-of-frame bit
//   state_t   : receive framing state
// ---------------------------------------------------------------------------
package tdm_pkg;

  localparam int LANES     = 4;
  localparam int SELW      = $clog2(LANES);
  localparam int LAST_LANE = LANES - 1;

  // HUNT: waiting for a start-of-frame marker. COLLECT: inside a frame.
  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// ---------------------------------------------------------------------------
// tdm_slot_ctr
// Slot down-counter that tracks the lane the next bit belongs to. Frames
// run from lane LANES-1 down to lane 0. The receive demux uses this block,
// and so does the transmit-side select sequencer.
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous, active-high reset (count = LANES-1)
//   i_load     in   1     load LANES-2 (the first bit of a frame was just taken)
//   i_reload   in   1     reload LANES-1 (the lane-0 bit was just taken)
//   i_dec      in   1     decrement by one
//   o_cnt      out  SELW  current slot
//   o_is_zero  out  1     current slot is lane 0
// When more than one command is asserted, the priority is load, then reload,
// then dec.
// ---------------------------------------------------------------------------
module tdm_slot_ctr #(
  parameter int LANES = 4,
  parameter int SELW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_reload,
  input  logic            i_dec,
  output logic [SELW-1:0] o_cnt,
  output logic            o_is_zero
);

  logic [SELW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples its pre-edge value, so the result does not depend on the order
  // in which always blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= SELW'(LANES - 1);
    end else if (i_load) begin
      r_cnt <= SELW'(LANES - 2);
    end else if (i_reload) begin
      r_cnt <= SELW'(LANES - 1);
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_is_zero = (r_cnt == '0);

endmodule

// File: rtl/tdm_demux1x4.sv
// ---------------------------------------------------------------------------
// tdm_demux1x4
// Receive end of the 4:1 time-division link. This block rebuilds each
// parallel word from the serial slot stream. Bits arrive in the order
// lane LANES-1 down to lane 0, and the first bit of each frame is marked
// with sof. A completed word is presented with a one-cycle vld pulse.
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous, active-high reset
//   din       in   1      serial data bit for the current slot
//   en        in   1      din/sof qualified this cycle (all inputs ignored when low)
//   sof       in   1      with en: din is the first bit of a frame (lane LANES-1)
//   y         out  LANES  last complete word; y[k] = bit received in slot k
//   vld       out  1      one-cycle pulse: y updated this cycle
//   s         out  SELW   lane the next qualified bit is written to
//   sync_err  out  1      one-cycle pulse: sof arrived mid-frame, partial discarded
// ---------------------------------------------------------------------------
module tdm_demux1x4
  import tdm_pkg::*;
#(
  parameter int LANES = tdm_pkg::LANES,
  parameter int SELW  = tdm_pkg::SELW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             sof,
  output logic [LANES-1:0] y,
  output logic             vld,
  output logic [SELW-1:0]  s,
  output logic             sync_err
);

  state_t           r_state;
  logic [LANES-1:0] r_word;      // partial word; it never drives y directly
  logic [LANES-1:0] r_y;
  logic             r_vld;
  logic             r_sync_err;

  state_t           w_state_nxt;
  logic [LANES-1:0] w_word_nxt;
  logic [LANES-1:0] w_y_nxt;
  logic             w_vld_nxt;
  logic             w_sync_err_nxt;
  logic             w_load;
  logic             w_reload;
  logic             w_dec;
  logic [SELW-1:0]  w_slot;
  logic             w_slot_zero;

  tdm_slot_ctr #(
    .LANES (LANES),
    .SELW  (SELW)
  ) u_slot_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_reload  (w_reload),
    .i_dec     (w_dec),
    .o_cnt     (w_slot),
    .o_is_zero (w_slot_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HUNT;
      r_word     <= '0;
      r_y        <= '0;
      r_vld      <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_word     <= w_word_nxt;
      r_y        <= w_y_nxt;
      r_vld      <= w_vld_nxt;
      r_sync_err <= w_sync_err_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first. That way no
    // path through the case statement leaves a signal unassigned, and no
    // latch is inferred. The defaults also make vld and sync_err one-cycle
    // pulses.
    w_state_nxt    = r_state;
    w_word_nxt     = r_word;
    w_y_nxt        = r_y;
    w_vld_nxt      = 1'b0;
    w_sync_err_nxt = 1'b0;
    w_load         = 1'b0;
    w_reload       = 1'b0;
    w_dec          = 1'b0;

    if (en) begin
      unique case (r_state)
        HUNT: begin
          // Bits without sof are dropped until a frame start is seen.
          if (sof) begin
            w_word_nxt            = '0;
            w_word_nxt[LAST_LANE] = din;
            w_load                = 1'b1;
            w_state_nxt           = COLLECT;
          end
        end
        COLLECT: begin
          if (sof) begin
            // A mid-frame sof wins, even on the lane-0 slot. The partial
            // word is thrown away and this bit starts a new frame.
            w_sync_err_nxt        = 1'b1;
            w_word_nxt            = '0;
            w_word_nxt[LAST_LANE] = din;
            w_load                = 1'b1;
          end else begin
            w_word_nxt[w_slot] = din;
            if (w_slot_zero) begin
              // The published word includes the bit captured on this edge.
              w_y_nxt     = w_word_nxt;
              w_vld_nxt   = 1'b1;
              w_reload    = 1'b1;
              w_state_nxt = HUNT;
            end else begin
              w_dec = 1'b1;
            end
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  assign y        = r_y;
  assign vld      = r_vld;
  assign s        = w_slot;
  assign sync_err = r_sync_err;

endmodule

// File: tb/tb_tdm_demux1x4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux1x4
// Directed and random stimulus for tdm_demux1x4. The reference model keeps
// the bits of the current frame in a queue and assembles words from slot
// order.
// ---------------------------------------------------------------------------
module tb_tdm_demux1x4;
  import tdm_pkg::*;

  localparam int L = tdm_pkg::LANES;
  localparam int W = tdm_pkg::SELW;

  logic         clk = 1'b0;
  logic         rst;
  logic         din;
  logic         en;
  logic         sof;
  logic [L-1:0] y;
  logic         vld;
  logic [W-1:0] s;
  logic         sync_err;

  tdm_demux1x4 #(.LANES(L), .SELW(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .en       (en),
    .sof      (sof),
    .y        (y),
    .vld      (vld),
    .s        (s),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the bits of the frame in progress, oldest first.
  bit           m_q[$];
  logic [L-1:0] m_y;
  logic         m_vld;
  logic         m_err;
  int           n_vld = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_y   = '0;
    m_vld = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic sf, input logic d);
    m_vld = 1'b0;
    m_err = 1'b0;
    if (e) begin
      if (sf) begin
        if (m_q.size() != 0) m_err = 1'b1;
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() != 0) begin
        m_q.push_back(d);
        if (m_q.size() == L) begin
          // First bit received belongs to lane L-1, last to lane 0.
          for (int i = 0; i < L; i++) m_y[L-1-i] = m_q[i];
          m_vld = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] exp_s;
    exp_s = W'(L - 1 - m_q.size());
    check({tag, " y"},        32'(y),        32'(m_y));
    check({tag, " vld"},      32'(vld),      32'(m_vld));
    check({tag, " s"},        32'(s),        32'(exp_s));
    check({tag, " sync_err"}, 32'(sync_err), 32'(m_err));
  endtask

  task automatic cycle(input string tag, input logic e, input logic sf, input logic d);
    en  = e;
    sof = sf;
    din = d;
    model_step(e, sf, d);
    @(posedge clk);
    #1;
    if (vld === 1'b1) n_vld++;
    check_all(tag);
  endtask

  task automatic send_frame(input string tag, input logic [L-1:0] w);
    for (int i = L - 1; i >= 0; i--) cycle(tag, 1'b1, (i == L - 1), w[i]);
  endtask

  initial begin
    logic [L-1:0] w;
    int           vld_before;

    // 1: reset, and reset asserted mid-frame.
    rst = 1'b1; en = 1'b0; sof = 1'b0; din = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("t1_reset");
    check("t1_reset_s3", 32'(s), 32'd3);
    rst = 1'b0;
    cycle("t1_idle", 1'b0, 1'b0, 1'b0);
    cycle("t1_f0", 1'b1, 1'b1, 1'b1);
    cycle("t1_f1", 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t1_rst_mid");
    @(negedge clk);
    rst = 1'b0;
    check_all("t1_rst_rel");

    // 2: clean frame 1010; vld must last exactly one cycle.
    send_frame("t2", 4'b1010);
    check("t2_y_const", 32'(y), 32'hA);
    check("t2_vld_on", 32'(vld), 32'd1);
    cycle("t2_after", 1'b0, 1'b0, 1'b0);
    check("t2_vld_off", 32'(vld), 32'd0);

    // 3: a bit without sof in HUNT is dropped, then the good frame 0110.
    cycle("t3_hunt", 1'b1, 1'b0, 1'b1);
    check("t3_hunt_s", 32'(s), 32'd3);
    send_frame("t3", 4'b0110);
    check("t3_y_const", 32'(y), 32'h6);

    // 4: frame 1100 with en=0 gaps; sof with en=0 must be ignored.
    cycle("t4_b3", 1'b1, 1'b1, 1'b1);
    cycle("t4_gap", 1'b0, 1'b0, 1'b0);
    cycle("t4_gap_sof", 1'b0, 1'b1, 1'b0);
    check("t4_gap_s", 32'(s), 32'd2);
    cycle("t4_b2", 1'b1, 1'b0, 1'b1);
    cycle("t4_gap2", 1'b0, 1'b0, 1'b1);
    cycle("t4_b1", 1'b1, 1'b0, 1'b0);
    cycle("t4_b0", 1'b1, 1'b0, 1'b0);
    check("t4_y_const", 32'(y), 32'hC);

    // 5: sof on the 2nd bit restarts the frame; it then completes as 0011.
    vld_before = n_vld;
    cycle("t5_b3", 1'b1, 1'b1, 1'b1);
    cycle("t5_resync", 1'b1, 1'b1, 1'b0);
    check("t5_err", 32'(sync_err), 32'd1);
    cycle("t5_b2", 1'b1, 1'b0, 1'b0);
    check("t5_err_pulse", 32'(sync_err), 32'd0);
    cycle("t5_b1", 1'b1, 1'b0, 1'b1);
    cycle("t5_b0", 1'b1, 1'b0, 1'b1);
    check("t5_y_const", 32'(y), 32'h3);
    check("t5_one_vld", 32'(n_vld - vld_before), 32'd1);

    // sof in the lane-0 slot: sof wins, no vld, and y keeps 0011.
    cycle("t5b_b3", 1'b1, 1'b1, 1'b0);
    cycle("t5b_b2", 1'b1, 1'b0, 1'b0);
    cycle("t5b_b1", 1'b1, 1'b0, 1'b0);
    cycle("t5b_b0sof", 1'b1, 1'b1, 1'b1);
    check("t5b_no_vld", 32'(vld), 32'd0);
    check("t5b_y_hold", 32'(y), 32'h3);
    cycle("t5b_c2", 1'b1, 1'b0, 1'b1);
    cycle("t5b_c1", 1'b1, 1'b0, 1'b1);
    cycle("t5b_c0", 1'b1, 1'b0, 1'b1);
    check("t5b_y", 32'(y), 32'hF);

    // 6: back-to-back frames 1010 and 0101 with no idle cycle.
    send_frame("t6a", 4'b1010);
    check("t6_y1", 32'(y), 32'hA);
    send_frame("t6b", 4'b0101);
    check("t6_y2", 32'(y), 32'h5);

    // Random traffic: mostly valid frames, with sof noise and en gaps.
    for (int n = 0; n < 400; n++) begin
      logic e, sf;
      e  = ($urandom_range(0, 3) != 0);
      sf = ($urandom_range(0, 4) == 0);
      cycle("rand", e, sf, 1'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        w = L'($urandom);
        send_frame("rand_frame", w);
        check("rand_frame_y", 32'(y), 32'(w));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
